regbank_write_arbiter: RTL

REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

---
 rtl/regbank_write_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
// Two-requester write arbiter in front of an 8-entry, 4-bit register bank.
// After reset it clears all eight registers, one per cycle. It then grants
// one write request at a time, with at most one write every two cycles.
// It also steps a free-running scan read address for display port A.
//
// Optional feature: define ROUND_ROBIN_EN to select round-robin arbitration.
// When two requests arrive together, the requester not granted last wins.
// Without the macro, requester 0 has fixed priority.
module regbank_write_arbiter #(
  parameter int unsigned SCAN_DIV = 4  // clock cycles per scan-address step, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] addr0,
  input  logic [2:0] addr1,
  input  logic [3:0] dat0,
  input  logic [3:0] dat1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [2:0] addrW,
  output logic [3:0] datW,
  output logic       RegWrite,
  output logic [2:0] addrRa,
  output logic       init_done
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

  state_e     state_q,     state_d;
  logic [2:0] init_cnt_q,  init_cnt_d;
  logic [2:0] addr_w_q,    addr_w_d;
  logic [3:0] dat_w_q,     dat_w_d;
  logic       reg_write_q, reg_write_d;
  logic       gnt0_q,      gnt0_d;
  logic       gnt1_q,      gnt1_d;
  logic       init_done_q, init_done_d;
  logic [2:0] addr_ra_q,   addr_ra_d;
  logic [7:0] scan_cnt_q,  scan_cnt_d;
  logic       pick1;

`ifdef ROUND_ROBIN_EN
  // 1 means requester 1 was granted last, so requester 0 is favoured next.
  logic       last_q,      last_d;

  // Arbitration: a lone requester wins; on a tie, the one not granted last wins.
  always_comb begin
    pick1 = req1 & (~req0 | ~last_q);
  end
`else
  // Arbitration: fixed priority, requester 0 wins every tie.
  always_comb begin
    pick1 = req1 & ~req0;
  end
`endif

  // Main control: clear sequence, request capture and the one-cycle write slot.
  always_comb begin
    // NOTE: every combinational output gets a default first, so that no path
    // through the case statement leaves one unassigned. An unassigned output
    // would infer a latch.
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    addr_w_d    = addr_w_q;
    dat_w_d     = dat_w_q;
    reg_write_d = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    init_done_d = init_done_q;
`ifdef ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_INIT: begin
        // Requests are left pending here; they are first seen in IDLE.
        reg_write_d = 1'b1;
        addr_w_d    = init_cnt_q;
        dat_w_d     = 4'd0;
        init_cnt_d  = init_cnt_q + 3'd1;
        if (init_cnt_q == 3'd7) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        init_done_d = 1'b1;
        if (req0 | req1) begin
          state_d     = ST_WRITE;
          reg_write_d = 1'b1;
          gnt0_d      = ~pick1;
          gnt1_d      = pick1;
          addr_w_d    = pick1 ? addr1 : addr0;
          dat_w_d     = pick1 ? dat1  : dat0;
`ifdef ROUND_ROBIN_EN
          last_d      = pick1;
`endif
        end
      end
      ST_WRITE: begin
        // The write is visible for exactly this cycle; requests are not
        // sampled here, so a held request is seen again in the next IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Scan divider: addrRa steps once every SCAN_DIV cycles, whatever the state.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 8'd1;
    addr_ra_d  = addr_ra_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 8'd0;
      addr_ra_d  = addr_ra_q + 3'd1;
    end
  end

  // State and registered outputs; reset aborts any clear or write in progress.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this block contains only small control registers and no storage
    // array, so every flop is reset. All of them use non-blocking assignments,
    // so each one updates from the values held before the clock edge.
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= 3'd0;
      addr_w_q    <= 3'd0;
      dat_w_q     <= 4'd0;
      reg_write_q <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      init_done_q <= 1'b0;
      addr_ra_q   <= 3'd0;
      scan_cnt_q  <= 8'd0;
`ifdef ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      addr_w_q    <= addr_w_d;
      dat_w_q     <= dat_w_d;
      reg_write_q <= reg_write_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      init_done_q <= init_done_d;
      addr_ra_q   <= addr_ra_d;
      scan_cnt_q  <= scan_cnt_d;
`ifdef ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign addrW     = addr_w_q;
  assign datW      = dat_w_q;
  assign RegWrite  = reg_write_q;
  assign addrRa    = addr_ra_q;
  assign init_done = init_done_q;

endmodule
